uart_rx: RTL and testbench
==========================

# uart_rx

Serial receiver for the UART link: the receiving end of the 8N1 frame (start bit, 8 data bits LSB-first, stop bit) produced by the UART1 transmitter on tx1. It synchronizes the asynchronous serial line `rx2` into the system clock domain, locates each frame by its start edge, samples every bit at mid-bit, and presents the byte with a one-cycle valid strobe. It is the block instantiated on the UART2 side of the link.

## Interface
- `CLKS_PER_BIT`, default 16: `clk_sis` cycles per bit period. Must be even and ≥ 4.
- `clk_sis` input 1: system clock. The only clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `rx2` input 1: serial line, idle high, asynchronous to `clk_sis`.
- `data_out` output 8: last correctly received byte. Held until the next good frame.
- `data_valid` output 1: one-cycle pulse when `data_out` updates.
- `frame_err` output 1: one-cycle pulse when the stop bit samples low.
- `busy` output 1: high in every state except IDLE.
- `parity_err` output 1: present only with `UART_RX_PARITY_EN`; one-cycle pulse on parity mismatch.

## Operation
- `rx2` passes through a 2-flop synchronizer (reset value 1). All logic uses the synchronized value `rx_s`.
- **IDLE**
  - Bit counter is 0.
  - On `rx_s == 0`: go to START and clear the cycle counter.
- **START**
  - Count to `CLKS_PER_BIT/2 - 1` (mid-start).
  - If `rx_s` is high there: false start; return to IDLE with no outputs.
  - Otherwise: clear the counter and go to DATA.
- **DATA**
  - Every `CLKS_PER_BIT` cycles, sample `rx_s` into shift register bit [bit_cnt] (LSB first).
  - After bit 7: go to PARITY (if enabled) or STOP.
- **PARITY** (macro only): sample once after `CLKS_PER_BIT` cycles, then go to STOP.
- **STOP**: sample after `CLKS_PER_BIT` cycles.
  - Sample high, and no parity error: load `data_out`, pulse `data_valid`, go to IDLE.
  - Sample low: pulse `frame_err`; `data_out` is unchanged; go to BREAK.
  - Sample high with a parity error: pulse `parity_err`; `data_valid` stays low; `data_out` is unchanged; go to IDLE.
- **BREAK**: wait until `rx_s == 1`, then go to IDLE. A held-low line produces exactly one `frame_err`.
- Back-to-back frames: a start edge seen in IDLE on the cycle right after STOP is accepted. No idle gap is required beyond the stop bit.
- No flow control. A new byte overwrites `data_out` whether or not the consumer used the previous one.

## Timing
- Reset values:
  - `data_out = 8'h00`; `data_valid`, `frame_err`, `parity_err` = 0; `busy` = 0.
  - State = IDLE; all counters = 0; synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately and emits no pulses. After release the receiver waits for a fresh falling edge; a line that is still low puts it in START.
- Let N = `CLKS_PER_BIT`, and let edge 0 be the first `clk_sis` edge that samples `rx2` low.
  - State enters START at edge 2.
  - Mid-start sample at edge 2 + N/2.
  - Data bit k is sampled at edge 2 + N/2 + (k+1)·N.
  - Stop is sampled at edge 2 + N/2 + 9N (+N with parity).
  - `data_valid` / `frame_err` are high for the cycle following the stop sample.
- `busy` rises at edge 2 and falls with the `data_valid` pulse (later if BREAK is entered).
- Counter widths are `$clog2(CLKS_PER_BIT)` for the cycle counter and 3 bits for the bit counter. Neither wraps mid-bit.

## Configuration
- `UART_RX_PARITY_EN`
  - Defined:
    - Frame is 8E1: one even-parity bit follows bit 7.
    - PARITY state and the `parity_err` port exist.
    - Expected parity = XOR of the 8 data bits.
  - Undefined:
    - Frame is 8N1.
    - No PARITY state and no `parity_err` port.

## Structure
- Shared package `uart_pkg`:
  - State enum: IDLE, START, DATA, PARITY, STOP, BREAK.
  - `UART_DATA_W = 8`.
  - Default `CLKS_PER_BIT`.
  - The transmitter side uses the same package.
- One sub-module: `uart_sync2`, the 2-flop synchronizer, async active-low reset to 1.

## Test plan
- N=16, send 8'hA5 as 8N1 with correct bit timing → one `data_valid` at edge 2+8+144+1 = 155; `data_out = 8'hA5`; `frame_err` never asserted.
- Send 8'h00 then 8'hFF back-to-back with no idle gap → two `data_valid` pulses exactly 160 cycles apart; values 00 then FF.
- Pull `rx2` low for 5 cycles only (glitch) → returns to IDLE; no pulses; `busy` high for at most 9 cycles.
- Frame 8'h3C with stop bit driven low, then hold low 40 cycles → one `frame_err`; `data_out` keeps its previous value; no further frame is accepted until `rx2` returns high.
- Assert `rst` during data bit 4 of a frame, release, then send 8'h5A → no pulses from the aborted frame; 8'h5A is received correctly.
- With `UART_RX_PARITY_EN`, send 8'h07 with parity bit 0 (wrong; expected 1) → one `parity_err`; no `data_valid`. Resend with parity bit 1 → `data_valid`, `data_out = 8'h07`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter state encoding, data width, default bit period.
package uart_pkg;

  localparam int unsigned UART_DATA_W          = 8;
  localparam int unsigned CLKS_PER_BIT_DEFAULT = 16;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop,
    StBreak
  } uart_state_e;

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus received-byte signals of the UART receiver.
// parity_err exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;

  logic                               rx2;
  logic [uart_pkg::UART_DATA_W-1:0]   data_out;
  logic                               data_valid;
  logic                               frame_err;
  logic                               busy;
`ifdef UART_RX_PARITY_EN
  logic                               parity_err;
`endif

  // master: the receiver; slave: the byte consumer (and line driver).
  modport master (
    input  rx2,
    output data_out,
    output data_valid,
    output frame_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output busy
  );

  modport slave (
    output rx2,
    input  data_out,
    input  data_valid,
    input  frame_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  busy
  );

endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      q_o    <= 1'b1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1 with an even-parity check when UART_RX_PARITY_EN is defined.
// Every bit is sampled at mid-bit, timed from the synchronized start edge.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
  input  logic      clk_sis,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntBitEnd  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalfEnd = CntW'(CLKS_PER_BIT / 2 - 1);

  logic rx_s;

  uart_sync2 u_sync2 (
    .clk_i  (clk_sis),
    .rst_ni (rst),
    .d_i    (bus.rx2),
    .q_o    (rx_s)
  );

  uart_state_e            state_q;
  logic [CntW-1:0]        cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [UART_DATA_W-1:0] shreg_q;
  logic [UART_DATA_W-1:0] data_q;
  logic                   valid_q;
  logic                   ferr_q;
`ifdef UART_RX_PARITY_EN
  logic                   par_q;
  logic                   perr_q;
`endif

  logic bit_end;
  logic par_bad;

  assign bit_end = (cnt_q == CntBitEnd);

`ifdef UART_RX_PARITY_EN
  // Even parity: the parity bit must equal the XOR of the data bits.
  assign par_bad = (par_q != ^shreg_q);
`else
  assign par_bad = 1'b0;
`endif

  always_ff @(posedge clk_sis or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q     <= 1'b0;
      perr_q    <= 1'b0;
`endif
    end else begin
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          bit_cnt_q <= '0;
          if (!rx_s) begin
            state_q <= StStart;
            cnt_q   <= '0;
          end
        end

        StStart: begin
          if (cnt_q == CntHalfEnd) begin
            cnt_q   <= '0;
            // A line back high at mid-start was a glitch, not a frame.
            state_q <= rx_s ? StIdle : StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        StData: begin
          if (bit_end) begin
            cnt_q              <= '0;
            shreg_q[bit_cnt_q] <= rx_s;
            bit_cnt_q          <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
              state_q <= StParity;
`else
              state_q <= StStop;
`endif
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

`ifdef UART_RX_PARITY_EN
        StParity: begin
          if (bit_end) begin
            cnt_q   <= '0;
            par_q   <= rx_s;
            state_q <= StStop;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
`endif

        StStop: begin
          if (bit_end) begin
            cnt_q <= '0;
            if (!rx_s) begin
              ferr_q  <= 1'b1;
              state_q <= StBreak;
            end else if (par_bad) begin
`ifdef UART_RX_PARITY_EN
              perr_q  <= 1'b1;
`endif
              state_q <= StIdle;
            end else begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end

        // Held-low line: one frame_err already reported, wait for the line to recover.
        StBreak: begin
          if (rx_s) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;
  assign bus.frame_err  = ferr_q;
  assign bus.busy       = (state_q != StIdle);
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_q;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: per-cycle expectation tables built from frame timing,
// randomized frames, glitches, breaks and mid-frame reset. Honors UART_RX_PARITY_EN.
module tb_uart_rx;

  localparam int N    = 16;
  localparam int MAXC = 20000;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;

  uart_rx_if bus_if ();

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk_sis (clk),
    .rst     (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Expected outputs per cycle index (observed after posedge number cyc).
  bit       exp_valid [MAXC];
  bit       exp_ferr  [MAXC];
  bit       exp_perr  [MAXC];
  bit       exp_busy  [MAXC];
  bit [7:0] exp_dval  [MAXC];

  int n_cmp = 0;
  int n_err = 0;
  int n_valid = 0;
  int n_ferr = 0;
  int n_perr = 0;
  int n_busy = 0;
  int last_e0 = 0;
  int vtimes[$];
  logic [7:0] md = 8'h00;

  task automatic check(input string name, input bit ok, input int act, input int req);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_busy(input int from, input int to, input bit v);
    for (int t = from; t <= to && t < MAXC; t++) exp_busy[t] = v;
  endtask

  task automatic clear_from(input int from);
    for (int t = from; t < MAXC; t++) begin
      exp_valid[t] = 1'b0;
      exp_ferr[t]  = 1'b0;
      exp_perr[t]  = 1'b0;
      exp_busy[t]  = 1'b0;
    end
  endtask

  task automatic drive(input logic v);
    bus_if.rx2 = v;
    tick(N);
  endtask

  // One full frame. Edge 0 is the next posedge; stop sample at e0 + 2 + N/2 + 9N (+N parity).
  task automatic send_frame(input logic [7:0] b, input bit stop_bit, input bit par_wrong);
    int e0;
    int s;
    e0 = cyc + 1;
    s  = e0 + 2 + N / 2 + 9 * N + P * N;
    last_e0 = e0;
    set_busy(e0 + 2, s - 1, 1'b1);
    if (!stop_bit) begin
      exp_ferr[s] = 1'b1;
      set_busy(s, MAXC - 1, 1'b1);
    end else if (P == 1 && par_wrong) begin
      exp_perr[s] = 1'b1;
    end else begin
      exp_valid[s] = 1'b1;
      exp_dval[s]  = b;
    end
    drive(1'b0);
    for (int i = 0; i < 8; i++) drive(b[i]);
`ifdef UART_RX_PARITY_EN
    drive((^b) ^ par_wrong);
`endif
    drive(stop_bit);
  endtask

  // Release a held-low line: the receiver leaves BREAK three edges after the line rises.
  task automatic line_high();
    bus_if.rx2 = 1'b1;
    set_busy(cyc + 3, MAXC - 1, 1'b0);
    tick(N);
  endtask

  // Low pulse shorter than half a bit: START is entered, then abandoned at mid-start.
  task automatic glitch(input int len);
    int e0;
    e0 = cyc + 1;
    set_busy(e0 + 2, e0 + 1 + N / 2, 1'b1);
    bus_if.rx2 = 1'b0;
    tick(len);
    bus_if.rx2 = 1'b1;
    tick(N);
  endtask

  task automatic abort_with_reset(input logic [7:0] b);
    int e0;
    e0 = cyc + 1;
    set_busy(e0 + 2, MAXC - 1, 1'b1);
    drive(1'b0);
    for (int i = 0; i < 4; i++) drive(b[i]);
    bus_if.rx2 = b[4];
    tick(N / 2);
    rst = 1'b0;
    clear_from(cyc);
    bus_if.rx2 = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(2);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      md = 8'h00;
      check("rst_data_out", bus_if.data_out === 8'h00, int'(bus_if.data_out), 0);
      check("rst_data_valid", bus_if.data_valid === 1'b0, int'(bus_if.data_valid), 0);
      check("rst_frame_err", bus_if.frame_err === 1'b0, int'(bus_if.frame_err), 0);
      check("rst_busy", bus_if.busy === 1'b0, int'(bus_if.busy), 0);
    end else if (cyc < MAXC) begin
      if (exp_valid[cyc]) md = exp_dval[cyc];
      check("data_valid", bus_if.data_valid === exp_valid[cyc],
            int'(bus_if.data_valid), int'(exp_valid[cyc]));
      check("frame_err", bus_if.frame_err === exp_ferr[cyc],
            int'(bus_if.frame_err), int'(exp_ferr[cyc]));
      check("data_out", bus_if.data_out === md, int'(bus_if.data_out), int'(md));
      check("busy", bus_if.busy === exp_busy[cyc], int'(bus_if.busy), int'(exp_busy[cyc]));
`ifdef UART_RX_PARITY_EN
      check("parity_err", bus_if.parity_err === exp_perr[cyc],
            int'(bus_if.parity_err), int'(exp_perr[cyc]));
      if (bus_if.parity_err === 1'b1) n_perr++;
`endif
      if (bus_if.data_valid === 1'b1) begin
        n_valid++;
        vtimes.push_back(cyc);
      end
      if (bus_if.frame_err === 1'b1) n_ferr++;
      if (bus_if.busy === 1'b1) n_busy++;
    end
  end

  initial begin
    #(10 * (MAXC - 500));
    $display("FAIL watchdog: actual timeout required finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0;
    int f0;
    int v0;
    bus_if.rx2 = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(3);

    // 8'hA5: valid pulse seen 154 (170 with parity) edges after edge 0.
    send_frame(8'hA5, 1'b1, 1'b0);
    tick(2);
    check("a5_count", vtimes.size() == 1, vtimes.size(), 1);
    if (vtimes.size() == 1)
      check("a5_latency", vtimes[0] - last_e0 == (P ? 170 : 154), vtimes[0] - last_e0,
            (P ? 170 : 154));
    check("a5_value", bus_if.data_out === 8'hA5, int'(bus_if.data_out), 'hA5);

    // Back-to-back 00 then FF: pulses one frame (160 / 176 cycles) apart.
    tick(5);
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    tick(2);
    check("b2b_count", vtimes.size() == 3, vtimes.size(), 3);
    if (vtimes.size() == 3)
      check("b2b_spacing", vtimes[2] - vtimes[1] == (P ? 176 : 160), vtimes[2] - vtimes[1],
            (P ? 176 : 160));
    check("b2b_value", bus_if.data_out === 8'hFF, int'(bus_if.data_out), 'hFF);

    // 5-cycle glitch.
    b0 = n_busy;
    v0 = n_valid;
    glitch(5);
    check("glitch_busy_cycles", (n_busy - b0) <= 9 && (n_busy - b0) > 0, n_busy - b0, 9);
    check("glitch_no_valid", n_valid == v0, n_valid, v0);

    // Stop bit low, line held low 40 more cycles.
    f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 1'b0);
    tick(40);
    line_high();
    check("break_one_ferr", n_ferr - f0 == 1, n_ferr - f0, 1);
    check("break_data_kept", bus_if.data_out === 8'hFF, int'(bus_if.data_out), 'hFF);

    // Reset during data bit 4, then a clean frame.
    v0 = n_valid;
    abort_with_reset(8'h96);
    send_frame(8'h5A, 1'b1, 1'b0);
    tick(2);
    check("abort_5a_value", bus_if.data_out === 8'h5A, int'(bus_if.data_out), 'h5A);
    check("abort_one_valid", n_valid - v0 == 1, n_valid - v0, 1);

`ifdef UART_RX_PARITY_EN
    f0 = n_perr;
    v0 = n_valid;
    send_frame(8'h07, 1'b1, 1'b1);
    tick(2);
    check("par_err_pulse", n_perr - f0 == 1, n_perr - f0, 1);
    check("par_err_no_valid", n_valid == v0, n_valid, v0);
    send_frame(8'h07, 1'b1, 1'b0);
    tick(2);
    check("par_ok_value", bus_if.data_out === 8'h07, int'(bus_if.data_out), 'h07);
    check("par_ok_valid", n_valid - v0 == 1, n_valid - v0, 1);
`endif

    for (int f = 0; f < 30; f++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        glitch($urandom_range(1, N / 2));
      end else if (kind == 1) begin
        send_frame(8'($urandom), 1'b0, 1'b0);
        tick($urandom_range(0, 40));
        line_high();
      end else begin
        send_frame(8'($urandom), 1'b1, kind == 2);
      end
      if ($urandom_range(0, 1) == 1) tick($urandom_range(1, N));
    end
    tick(N);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
